// File: rtl/enc_axi_mem_responder.sv
// enc_axi_mem_responder: AXI4 slave backed by an on-chip word array.
// Read and write engines run independently, each with one burst in flight.
// Optional macro ENC_AXI_MEM_RANGE_CHECK_EN: beats beyond the array return
// DECERR, writes there are dropped, and the burst index no longer wraps.
module enc_axi_mem_responder #(
  parameter int AWIDTH    = 64,
  parameter int DWIDTH    = 128,
  parameter int MEM_DEPTH = 1024,
  parameter int IDX_W     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AWIDTH-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DWIDTH-1:0]   s_wdata,
  input  logic [DWIDTH/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [AWIDTH-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DWIDTH-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);
  localparam int NB = DWIDTH / 8;
  localparam int XW = AWIDTH - 4;   // full beat index width (addr[AWIDTH-1:4])
`ifdef ENC_AXI_MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DWIDTH-1:0] mem [MEM_DEPTH];

  // Beat size is fixed at 16 bytes and beats are aligned, so these are ignored.
  logic unused;
  assign unused = ^{s_awsize, s_arsize, s_awaddr[3:0], s_araddr[3:0]};

  // FIXED holds the index; everything else steps by one. Without range
  // checking only the low IDX_W bits step, so the index wraps in the array.
  function automatic logic [XW-1:0] next_idx(input logic [XW-1:0] idx, input logic [1:0] burst);
    logic [XW-1:0] n;
    if (burst == 2'b00) n = idx;
    else if (RC)        n = idx + XW'(1);
    else                n = {idx[XW-1:IDX_W], idx[IDX_W-1:0] + IDX_W'(1)};
    return n;
  endfunction

  function automatic logic oob(input logic [XW-1:0] idx);
    return RC && (|idx[XW-1:IDX_W]);
  endfunction

  // ---------------- write engine ----------------
  wstate_t       wstate;
  logic [XW-1:0] widx;
  logic [1:0]    wburst;
  logic [7:0]    wlen, wcnt;
  logic          last_err;
  logic          aw_hs, w_hs, wr_en, w_end;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign wr_en = w_hs & ~oob(widx);
  assign w_end = (wcnt == wlen);

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge clk)
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (s_wstrb[i]) mem[widx[IDX_W-1:0]][i*8 +: 8] <= s_wdata[i*8 +: 8];

  // Write FSM: accept address, absorb beats until wlast or len+1, respond.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wstate    <= W_IDLE;
      s_awready <= 1'b1;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= OKAY;
      widx      <= '0;
      wburst    <= '0;
      wlen      <= '0;
      wcnt      <= '0;
      last_err  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (aw_hs) begin
          widx      <= s_awaddr[AWIDTH-1:4];
          wburst    <= s_awburst;
          wlen      <= s_awlen;
          wcnt      <= '0;
          s_bresp   <= OKAY;
          s_awready <= 1'b0;
          s_wready  <= 1'b1;
          wstate    <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          widx <= next_idx(widx, wburst);
          wcnt <= wcnt + 8'd1;
          if (oob(widx)) s_bresp <= DECERR;
          if (s_wlast || w_end) begin
            // wlast disagreeing with the beat count still ends the burst
            if (s_wlast != w_end) last_err <= 1'b1;
            s_wready <= 1'b0;
            s_bvalid <= 1'b1;
            wstate   <= W_RESP;
          end
        end
        W_RESP: if (s_bready) begin
          s_bvalid  <= 1'b0;
          s_bresp   <= OKAY;
          s_awready <= 1'b1;
          wstate    <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end

  // ---------------- read engine ----------------
  rstate_t       rstate;
  logic [XW-1:0] ridx, ar_idx;
  logic [1:0]    rburst;
  logic [7:0]    rlen, rcnt;
  logic          ar_hs, r_hs;

  assign ar_idx = s_araddr[AWIDTH-1:4];
  assign ar_hs  = s_arvalid & s_arready;
  assign r_hs   = s_rvalid & s_rready;

  // Read FSM: data registered from the array one cycle after each request,
  // so a same-cycle write to the same word is not seen.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rstate    <= R_IDLE;
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rlast   <= 1'b0;
      s_rresp   <= OKAY;
      s_rdata   <= '0;
      ridx      <= '0;
      rburst    <= '0;
      rlen      <= '0;
      rcnt      <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (ar_hs) begin
          s_rdata   <= oob(ar_idx) ? '0 : mem[ar_idx[IDX_W-1:0]];
          s_rresp   <= oob(ar_idx) ? DECERR : OKAY;
          s_rlast   <= (s_arlen == 8'd0);
          s_rvalid  <= 1'b1;
          s_arready <= 1'b0;
          ridx      <= next_idx(ar_idx, s_arburst);
          rburst    <= s_arburst;
          rlen      <= s_arlen;
          rcnt      <= '0;
          rstate    <= R_DATA;
        end
        R_DATA: if (r_hs) begin
          if (s_rlast) begin
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_arready <= 1'b1;
            rstate    <= R_IDLE;
          end else begin
            s_rdata <= oob(ridx) ? '0 : mem[ridx[IDX_W-1:0]];
            s_rresp <= oob(ridx) ? DECERR : OKAY;
            s_rlast <= (rcnt + 8'd1 == rlen);
            ridx    <= next_idx(ridx, rburst);
            rcnt    <= rcnt + 8'd1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
endmodule

// File: tb/tb_enc_axi_mem_responder.sv
// Scoreboard bench for enc_axi_mem_responder: a word-array model predicts
// read data/responses, pushed at AR time and popped at each R handshake.
module tb_enc_axi_mem_responder;
  localparam int DEPTH = 1024;
`ifdef ENC_AXI_MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic         clk = 0, rst = 1;
  logic [63:0]  s_awaddr = 0, s_araddr = 0;
  logic [7:0]   s_awlen = 0, s_arlen = 0;
  logic [2:0]   s_awsize = 3'd4, s_arsize = 3'd4;
  logic [1:0]   s_awburst = 1, s_arburst = 1;
  logic         s_awvalid = 0, s_awready, s_arvalid = 0, s_arready;
  logic [127:0] s_wdata = 0, s_rdata;
  logic [15:0]  s_wstrb = 0;
  logic         s_wlast = 0, s_wvalid = 0, s_wready;
  logic [1:0]   s_bresp, s_rresp;
  logic         s_bvalid, s_bready = 0;
  logic         s_rlast, s_rvalid, s_rready = 0;

  enc_axi_mem_responder #(.AWIDTH(64), .DWIDTH(128), .MEM_DEPTH(DEPTH), .IDX_W(10)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [127:0] model [DEPTH];
  logic [127:0] wbuf [256];
  logic [15:0]  sbuf [256];
  logic [127:0] exp_q [$];
  logic [1:0]   expr_q [$];
  logic [127:0] last_rd;

  // AW + W beats (wlast on beat wlast_at; <0 means never) then B; model updated.
  task automatic do_write(input logic [63:0] addr, input int len, input logic [1:0] burst, input int wlast_at);
    longint unsigned fidx = addr >> 4;
    int beats = (wlast_at >= 0 && wlast_at < len) ? wlast_at + 1 : len + 1;
    logic [1:0] eb = 2'b00;
    int to;
    @(negedge clk);
    s_awaddr = addr; s_awlen = 8'(len); s_awburst = burst; s_awsize = 3'd4; s_awvalid = 1;
    to = 0; while (!s_awready && to < 50) begin @(negedge clk); to++; end
    total++; if (to >= 50) begin bad++; $display("FAIL aw_timeout addr=%h", addr); end
    @(negedge clk); s_awvalid = 0;
    for (int b = 0; b < beats; b++) begin
      s_wdata = wbuf[b]; s_wstrb = sbuf[b]; s_wlast = (b == wlast_at); s_wvalid = 1;
      to = 0; while (!s_wready && to < 50) begin @(negedge clk); to++; end
      total++; if (to >= 50) begin bad++; $display("FAIL w_timeout beat=%0d", b); end
      if (RC && fidx >= DEPTH) eb = 2'b11;
      else for (int i = 0; i < 16; i++)
        if (sbuf[b][i]) model[fidx % DEPTH][i*8 +: 8] = wbuf[b][i*8 +: 8];
      if (burst != 2'b00) fidx++;
      @(negedge clk);
    end
    s_wvalid = 0; s_wlast = 0;
    total++; if (s_wready !== 1'b0) begin bad++; $display("FAIL wready_after_burst got=%b want=0", s_wready); end
    s_bready = 1;
    to = 0; while (!s_bvalid && to < 50) begin @(negedge clk); to++; end
    total++; if (s_bvalid !== 1'b1 || s_bresp !== eb)
      begin bad++; $display("FAIL bresp got=%b/%b want=1/%b", s_bvalid, s_bresp, eb); end
    @(negedge clk); s_bready = 0;
    total++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1)
      begin bad++; $display("FAIL b_done bvalid=%b awready=%b want 0/1", s_bvalid, s_awready); end
  endtask

  // AR then collect beats; stall toggles rready 1,0,1,0...
  task automatic do_read(input logic [63:0] addr, input int len, input logic [1:0] burst, input bit stall);
    longint unsigned fidx = addr >> 4;
    int got = 0, cyc = 0, to;
    bit held = 0;
    logic [127:0] hd, e;
    logic hl;
    logic [1:0] er;
    for (int b = 0; b <= len; b++) begin
      if (RC && fidx >= DEPTH) begin exp_q.push_back('0); expr_q.push_back(2'b11); end
      else begin exp_q.push_back(model[fidx % DEPTH]); expr_q.push_back(2'b00); end
      if (burst != 2'b00) fidx++;
    end
    @(negedge clk);
    s_araddr = addr; s_arlen = 8'(len); s_arburst = burst; s_arsize = 3'd4; s_arvalid = 1; s_rready = 0;
    to = 0; while (!s_arready && to < 50) begin @(negedge clk); to++; end
    total++; if (to >= 50 || s_rvalid !== 1'b0)
      begin bad++; $display("FAIL ar_accept to=%0d rvalid=%b", to, s_rvalid); end
    @(negedge clk); s_arvalid = 0;
    total++; if (s_rvalid !== 1'b1) begin bad++; $display("FAIL rvalid_latency got=%b want=1", s_rvalid); end
    while (got <= len && cyc < 2000) begin
      if (held) begin
        total++; if (s_rdata !== hd || s_rlast !== hl)
          begin bad++; $display("FAIL stall_stable got=%h/%b want=%h/%b", s_rdata, s_rlast, hd, hl); end
      end
      s_rready = stall ? (cyc % 2 == 0) : 1'b1;
      held = s_rvalid && !s_rready; hd = s_rdata; hl = s_rlast;
      if (s_rvalid && s_rready) begin
        e = exp_q.pop_front(); er = expr_q.pop_front();
        total++; if (s_rdata !== e) begin bad++; $display("FAIL rdata beat=%0d got=%h want=%h", got, s_rdata, e); end
        total++; if (s_rlast !== (got == len)) begin bad++; $display("FAIL rlast beat=%0d got=%b", got, s_rlast); end
        total++; if (s_rresp !== er) begin bad++; $display("FAIL rresp beat=%0d got=%b want=%b", got, s_rresp, er); end
        last_rd = s_rdata; got++;
      end
      cyc++; @(negedge clk);
    end
    s_rready = 0;
    exp_q.delete(); expr_q.delete();
    total++; if (got != len + 1) begin bad++; $display("FAIL read_beats got=%0d want=%0d", got, len + 1); end
    total++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1)
      begin bad++; $display("FAIL read_idle rvalid=%b arready=%b want 0/1", s_rvalid, s_arready); end
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    total++; if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast} !== 6'b110000)
      begin bad++; $display("FAIL reset_ctl got=%b want=110000", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast}); end
    total++; if (s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 128'h0)
      begin bad++; $display("FAIL reset_data bresp=%b rresp=%b rdata=%h", s_bresp, s_rresp, s_rdata); end
    total++; if (dut.last_err !== 1'b0) begin bad++; $display("FAIL reset_last_err got=%b want=0", dut.last_err); end
    rst = 0;
  endtask

  task automatic test_incr;
    for (int b = 0; b < 4; b++) begin wbuf[b] = {16{8'(8'hA0 + b)}}; sbuf[b] = '1; end
    do_write(64'h40, 3, 2'b01, 3);
    do_read(64'h40, 3, 2'b01, 0);
    total++; if (last_rd !== {16{8'hA3}}) begin bad++; $display("FAIL incr_last got=%h want=%h", last_rd, {16{8'hA3}}); end
  endtask

  task automatic test_strobe;
    wbuf[0] = '0; sbuf[0] = '1; do_write(64'h40, 0, 2'b01, 0);
    wbuf[0] = '1; sbuf[0] = 16'h00FF; do_write(64'h40, 0, 2'b01, 0);
    do_read(64'h40, 0, 2'b01, 0);
    total++; if (last_rd !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFF})
      begin bad++; $display("FAIL wstrb_merge got=%h", last_rd); end
  endtask

  task automatic test_stall;
    for (int b = 0; b < 8; b++) begin wbuf[b] = {4{32'(32'h1000 * b + b)}}; sbuf[b] = '1; end
    do_write(64'h200, 7, 2'b01, 7);
    do_read(64'h200, 7, 2'b01, 1);
  endtask

  task automatic test_fixed_wrap;
    for (int b = 0; b < 3; b++) begin wbuf[b] = {8{16'(16'hBEE0 + b)}}; sbuf[b] = '1; end
    do_write(64'h100, 2, 2'b00, 2);
    do_read(64'h100, 2, 2'b00, 0);
    total++; if (last_rd !== {8{16'hBEE2}}) begin bad++; $display("FAIL fixed_last got=%h", last_rd); end
    for (int b = 0; b < 2; b++) begin wbuf[b] = {8{16'(16'h7700 + b)}}; sbuf[b] = '1; end
    do_write(64'h3FF0, 1, 2'b10, 1);
    do_read(64'h3FF0, 1, 2'b11, 0);
  endtask

  task automatic test_same_cycle;
    wbuf[0] = 128'h11; sbuf[0] = '1; do_write(64'h50, 0, 2'b01, 0);
    @(negedge clk); s_awaddr = 64'h50; s_awlen = 0; s_awburst = 2'b01; s_awvalid = 1;
    @(negedge clk);
    s_awvalid = 0; s_wdata = 128'h22; s_wstrb = '1; s_wlast = 1; s_wvalid = 1;
    s_araddr = 64'h50; s_arlen = 0; s_arburst = 2'b01; s_arvalid = 1; s_rready = 0;
    @(negedge clk);
    s_wvalid = 0; s_wlast = 0; s_arvalid = 0;
    total++; if (s_rvalid !== 1'b1 || s_rdata !== 128'h11)
      begin bad++; $display("FAIL same_cycle_old rvalid=%b got=%h want=11", s_rvalid, s_rdata); end
    s_rready = 1; s_bready = 1;
    @(negedge clk); s_rready = 0; s_bready = 0;
    total++; if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0)
      begin bad++; $display("FAIL same_cycle_done bvalid=%b rvalid=%b", s_bvalid, s_rvalid); end
    model[5] = 128'h22;
    do_read(64'h50, 0, 2'b01, 0);
  endtask

  task automatic test_wlast_err;
    total++; if (dut.last_err !== 1'b0) begin bad++; $display("FAIL last_err_clean got=%b want=0", dut.last_err); end
    for (int b = 0; b < 4; b++) begin wbuf[b] = {16{8'(8'hC0 + b)}}; sbuf[b] = '1; end
    do_write(64'h300, 1, 2'b01, -1);
    total++; if (dut.last_err !== 1'b1) begin bad++; $display("FAIL last_err_missing got=%b want=1", dut.last_err); end
    test_reset();
    do_write(64'h300, 3, 2'b01, 3);
    for (int b = 0; b < 4; b++) wbuf[b] = {16{8'(8'hD0 + b)}};
    do_write(64'h300, 3, 2'b01, 1);
    total++; if (dut.last_err !== 1'b1) begin bad++; $display("FAIL last_err_early got=%b want=1", dut.last_err); end
    do_read(64'h300, 3, 2'b01, 0);
    total++; if (last_rd !== {16{8'hC3}}) begin bad++; $display("FAIL early_untouched got=%h", last_rd); end
  endtask

  task automatic test_reset_mid;
    int got = 0, cyc = 0;
    @(negedge clk); s_araddr = 64'h0; s_arlen = 8'd15; s_arburst = 2'b01; s_arvalid = 1; s_rready = 1;
    @(negedge clk); s_arvalid = 0;
    while (got < 6 && cyc < 100) begin
      if (s_rvalid) got++;
      cyc++; @(negedge clk);
    end
    total++; if (s_rvalid !== 1'b1) begin bad++; $display("FAIL mid_burst_active got=%b want=1", s_rvalid); end
    rst = 1; #1;
    total++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1 || s_rdata !== 128'h0)
      begin bad++; $display("FAIL reset_abort rvalid=%b arready=%b rdata=%h", s_rvalid, s_arready, s_rdata); end
    s_rready = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_range;
    wbuf[0] = {8{16'h5A5A}}; sbuf[0] = '1; do_write(64'h0, 0, 2'b01, 0);
    wbuf[0] = {8{16'h0F0F}}; do_write(64'h4000, 0, 2'b01, 0);
    do_read(64'h0, 0, 2'b01, 0);
`ifdef ENC_AXI_MEM_RANGE_CHECK_EN
    total++; if (last_rd !== {8{16'h5A5A}}) begin bad++; $display("FAIL range_unchanged got=%h", last_rd); end
    do_read(64'h4000, 0, 2'b01, 0);
`else
    total++; if (last_rd !== {8{16'h0F0F}}) begin bad++; $display("FAIL range_alias got=%h", last_rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_incr();
    test_strobe();
    test_stall();
    test_fixed_wrap();
    test_same_cycle();
    test_wlast_err();
    test_reset_mid();
    test_range();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enc_axi_mem_responder.md
Name: enc_axi_mem_responder

Overview:
- AXI4 memory-mapped slave (responder) that terminates the encoder's 128-bit AXI master port.
- Backed by an on-chip word array. Used as local reference/bitstream buffer and as the host-memory stand-in for block-level encoder sims.
- Full-burst slave with independent read and write engines, one outstanding transaction per direction.

Parameters:
AWIDTH, 64, AXI address width
DWIDTH, 128, AXI data width (bytes per beat = DWIDTH/8 = 16)
MEM_DEPTH, 1024, number of DWIDTH words in the array (power of two)
IDX_W, 10, log2(MEM_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_awaddr  in  AWIDTH  write address
s_awlen  in  8  beats-1
s_awsize  in  3  beat size (must be 4)
s_awburst  in  2  burst type
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DWIDTH  write data
s_wstrb  in  DWIDTH/8  byte enables
s_wlast  in  1  last write beat
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  AWIDTH  read address
s_arlen  in  8  beats-1
s_arsize  in  3  beat size
s_arburst  in  2  burst type
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DWIDTH  read data
s_rresp  out  2  read response
s_rlast  out  1  last read beat
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bresp=0, rresp=0, rdata=0.
  - Both FSMs in IDLE.
  - Array contents are not cleared.
- Word index = addr[IDX_W+3:4]. addr[3:0] is ignored (aligned beats only).
- Burst address update:
  - INCR (01) and WRAP (10): index+1 per beat, wrapping modulo MEM_DEPTH.
  - FIXED (00): index constant.
  - Reserved (11): treated as INCR.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1. On AW handshake, latch index, burst and len; go to W_DATA (awready=0, wready=1 next cycle).
  - W_DATA: on each W handshake, write every byte lane with wstrb[i]=1; other lanes are untouched. Advance index; increment beat counter.
  - Leave W_DATA when wlast=1 or beat count = len+1, whichever comes first. Then wready=0, bvalid=1, bresp=OKAY.
  - wlast arriving early, or missing at beat len+1: burst still terminates. An internal sticky flag, last_err, is set (visible to the bench hierarchically).
  - W_RESP: hold bvalid and bresp until bready. On handshake, return to W_IDLE with awready=1 the following cycle.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready=1. On AR handshake, rdata is registered from mem[index]; rvalid=1 on the next cycle (latency 1). rlast=1 if len=0.
  - R_DATA: on R handshake with remaining beats, rdata <= mem[next index] and rvalid stays 1. This gives one beat per cycle under continuous rready.
  - rlast is asserted exactly on beat len+1. Its handshake returns to R_IDLE (rvalid=0, arready=1 next cycle).
  - rvalid=1 with rready=0: rdata, rlast and rresp are held stable.
- Simultaneous read and write to the same index in one cycle: the read captures the pre-write value.
- Read and write engines run concurrently with no ordering between them.
- Reset mid-burst: both FSMs abort to IDLE, outputs return to reset values, and partially written data remains in the array.
- s_awsize/s_arsize other than 4: accepted and treated as 16-byte beats.

Optional Feature:
- Macro: ENC_AXI_MEM_RANGE_CHECK_EN.
- Defined:
  - Any beat whose byte address ≥ MEM_DEPTH*16 is a decode error: writes to it are suppressed and reads return rdata=0.
  - The burst's bresp, or that beat's rresp, is DECERR (2'b11). bresp is sticky across the burst.
  - The index does not wrap.
- Undefined: address bits above IDX_W+3 are ignored, the index wraps, and every response is OKAY.

Test Plan:
- Write INCR len=3 at 0x40 with data 0x...A0..A3 and wstrb all-ones, then read INCR len=3 at 0x40 -> rdata A0..A3, rlast on beat 4, bresp=0, rresp=0.
- Write 0x40 with wstrb=0x00FF and data all-FF over a word preloaded to 0 -> readback shows low 8 bytes=FF, high 8 bytes=00.
- Read len=7 with rready toggling 1,0,1,0 -> 8 beats in order, data stable while stalled, rvalid first asserted 1 cycle after AR handshake.
- Same-cycle write and read of index 5 (old=0x11, new=0x22) -> read returns 0x11; a subsequent read returns 0x22.
- Write burst len=3 with wlast on beat 2 -> burst ends after 2 beats, bvalid asserted, last_err=1. Assert rst during a len=15 read at beat 6 -> rvalid=0 and arready=1 immediately.
- With ENC_AXI_MEM_RANGE_CHECK_EN, MEM_DEPTH=1024: write at 0x4000 -> bresp=2'b11 and array unchanged. Without the macro, the same write lands at index 0 with bresp=0.
